// File: rtl/reg_dump_pkg.sv
// ---------------------------------------------------------------------------
// reg_dump_pkg
// Shared definitions for the register-bank dump reader: default sizing,
// the FSM state encoding and the reset constants used by the reader.
// ---------------------------------------------------------------------------
package reg_dump_pkg;

  // Default geometry of the architectural register bank
  localparam int NUM_REGS_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT   = 5;
  localparam int DATA_W_DEFAULT   = 32;

  // Dump engine states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

  // Reset constants for the single-bit controls and the state register
  localparam dump_state_t RST_STATE = IDLE;
  localparam logic        RST_VALID = 1'b0;
  localparam logic        RST_BUSY  = 1'b0;
  localparam logic        RST_DONE  = 1'b0;

endpackage

// File: rtl/reg_dump_reader.sv
// ---------------------------------------------------------------------------
// reg_dump_reader
// Debug read-out engine. On start it walks registers 0..NUM_REGS-1 through
// the asynchronous bank read port, offers each {address, data} pair on a
// valid/ready stream and accumulates an XOR checksum of accepted data.
// The bank is never written from here.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   start      begin a dump (only honoured in IDLE)
//   abort      cancel; back to IDLE next cycle, checksum keeps partial value
//   rd_addr    bank read address (combinational read data returns same cycle)
//   rd_data    bank read data
//   out_valid  pair valid
//   out_ready  consumer accepts the pair
//   out_addr   register index of the pair
//   out_data   register value captured during READ
//   busy       dump in progress (READ or SEND)
//   done       one-cycle pulse after the last pair is accepted
//   checksum   XOR of all accepted out_data of the last/current dump
// ---------------------------------------------------------------------------
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t       state;
  dump_state_t       next_state;
  logic [ADDR_W-1:0] idx;

  // Control strobes decoded from the current state and inputs
  logic launch;   // accepted start: clear index and checksum
  logic capture;  // READ cycle: latch bank data into the output register
  logic accept;   // handshake completes this cycle

  // Running checksum update
  function automatic logic [DATA_W-1:0] checksum_step(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] data
  );
    return acc ^ data;
  endfunction

  // The read port simply follows the index register; idx is a flop so
  // rd_addr is glitch-free and holds steady through SEND.
  assign rd_addr = idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control strobe decode; abort takes priority everywhere
  always_comb begin
    next_state = state;
    launch     = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (abort) begin
          next_state = IDLE;
        end else if (start) begin
          next_state = READ;
          launch     = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      READ: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          next_state = SEND;
          capture    = 1'b1;
        end
      end
      SEND: begin
        if (abort) begin
          next_state = IDLE;
        end else if (out_valid && out_ready) begin
          accept = 1'b1;
          // Terminal compare precedes the increment so idx never wraps
          if (idx == LAST_IDX) begin
            next_state = DONE;
          end else begin
            next_state = READ;
          end
        end else begin
          next_state = SEND;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Index counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= {ADDR_W{1'b0}};
    end else if (launch) begin
      idx <= {ADDR_W{1'b0}};
    end else if (accept && (idx != LAST_IDX)) begin
      idx <= idx + ADDR_W'(1);
    end else begin
      idx <= idx;
    end
  end

  // Output capture register: loaded only in READ, so a bank write landing
  // while the pair waits in SEND cannot disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_addr <= {ADDR_W{1'b0}};
      out_data <= {DATA_W{1'b0}};
    end else if (capture) begin
      out_addr <= idx;
      out_data <= rd_data;
    end else begin
      out_addr <= out_addr;
      out_data <= out_data;
    end
  end

  // Checksum accumulator; keeps its value between dumps and across abort
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= {DATA_W{1'b0}};
    end else if (launch) begin
      checksum <= {DATA_W{1'b0}};
    end else if (accept) begin
      checksum <= checksum_step(checksum, out_data);
    end else begin
      checksum <= checksum;
    end
  end

  // Status flags registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= RST_VALID;
      busy      <= RST_BUSY;
      done      <= RST_DONE;
    end else begin
      out_valid <= (next_state == SEND);
      busy      <= (next_state == READ) || (next_state == SEND);
      done      <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_reader
// Directed bench for reg_dump_reader with a behavioural register bank.
// ---------------------------------------------------------------------------
module tb_reg_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] bank     [16];
  logic [31:0] exp_data [16];

  int vectors;
  int miscompares;
  int pairs_seen;
  int done_count;
  int done_cycle;

  reg_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  // Asynchronous bank read port
  assign rd_data = bank[rd_addr[3:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 16; i++) exp_data[i] = bank[i];
  endtask

  // Called in cycle 0 with start already driven high
  task automatic run_dump(input int stall_idx, input int stall_len,
                          input int wr_idx, input logic [31:0] wr_val, input bit spam);
    int  stall_rem;
    int  extra;
    bit  written;
    bit  fresh;
    pairs_seen = 0;
    done_count = 0;
    done_cycle = -1;
    stall_rem  = stall_len;
    written    = 1'b0;
    fresh      = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) begin
        check_val("c1_rd_addr", {27'd0, rd_addr}, 32'd0);
        check_val("c1_busy", {31'd0, busy}, 32'd1);
        check_val("c1_valid", {31'd0, out_valid}, 32'd0);
      end
      if (out_valid) begin
        if (pairs_seen > 15) begin
          check_val("extra_pair", 32'(pairs_seen), 32'd15);
          out_ready = 1'b1;
        end else begin
          if (fresh) begin
            extra = (pairs_seen > stall_idx) ? stall_len : 0;
            check_val("pair_cycle", 32'(c), 32'(2 + 2 * pairs_seen + extra));
            fresh = 1'b0;
          end
          if ((int'(out_addr) == wr_idx) && !written) begin
            bank[wr_idx] = wr_val;
            written = 1'b1;
            #1;
          end
          check_val("out_addr", {27'd0, out_addr}, 32'(pairs_seen));
          check_val("out_data", out_data, exp_data[pairs_seen]);
          if ((int'(out_addr) == stall_idx) && (stall_rem > 0)) begin
            out_ready = 1'b0;
            stall_rem--;
          end else begin
            out_ready = 1'b1;
          end
          if (out_ready) begin
            pairs_seen++;
            fresh = 1'b1;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
        check_val("busy_at_done", {31'd0, busy}, 32'd0);
      end
      if (spam) start = busy;
      if ((done_cycle >= 0) && (c >= done_cycle + 2)) break;
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit found;
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    bank[0]  = 32'd0;   bank[1]  = 32'd5;   bank[2]  = 32'd2;   bank[3]  = 32'd20;
    bank[4]  = 32'd25;  bank[5]  = 32'd30;  bank[6]  = 32'd35;  bank[7]  = 32'd40;
    bank[8]  = 32'd45;  bank[9]  = 32'd50;  bank[10] = 32'd55;  bank[11] = 32'd60;
    bank[12] = 32'd65;  bank[13] = 32'd70;  bank[14] = 32'd75;  bank[15] = 32'd80;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    check_val("rst_out_addr", {27'd0, out_addr}, 32'd0);
    check_val("rst_out_data", out_data, 32'd0);
    check_val("rst_checksum", checksum, 32'd0);
    check_idle_outputs("rst");

    // Full dump, consumer always ready
    snapshot();
    start = 1'b1;
    run_dump(99, 0, 99, 32'd0, 1'b0);
    check_val("basic_pairs", 32'(pairs_seen), 32'd16);
    check_val("basic_done_cnt", 32'(done_count), 32'd1);
    check_val("basic_done_cyc", 32'(done_cycle), 32'd33);
    check_val("basic_checksum", checksum, 32'h17);

    // Backpressure: three stalled cycles on idx 4
    tick();
    snapshot();
    start = 1'b1;
    run_dump(4, 3, 99, 32'd0, 1'b0);
    check_val("bp_pairs", 32'(pairs_seen), 32'd16);
    check_val("bp_done_cnt", 32'(done_count), 32'd1);
    check_val("bp_done_cyc", 32'(done_cycle), 32'd36);
    check_val("bp_checksum", checksum, 32'h17);

    // Abort while idx 9 waits in SEND; abort beats the handshake
    tick();
    snapshot();
    start = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start = 1'b0;
      if (out_valid && (out_addr == 5'd9)) begin
        found = 1'b1;
        break;
      end
    end
    check_val("abort_reach", {31'd0, found}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("abort");
    check_val("abort_checksum", checksum, 32'h32);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle_outputs("abort_after");
    end

    // Restart after abort with start hammered while busy
    snapshot();
    start = 1'b1;
    run_dump(99, 0, 99, 32'd0, 1'b1);
    check_val("spam_pairs", 32'(pairs_seen), 32'd16);
    check_val("spam_done_cnt", 32'(done_count), 32'd1);
    check_val("spam_done_cyc", 32'(done_cycle), 32'd33);
    check_val("spam_checksum", checksum, 32'h17);
    check_idle_outputs("spam_end");

    // start and abort together in IDLE: stay idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_idle_outputs("start_abort");

    // Bank write to reg 7 while its pair is pending (stalled one cycle)
    snapshot();
    start = 1'b1;
    run_dump(7, 1, 7, 32'hDEAD, 1'b0);
    check_val("wr_pairs", 32'(pairs_seen), 32'd16);
    check_val("wr_checksum", checksum, 32'h17);

    // Second dump sees the new value
    tick();
    snapshot();
    check_val("wr_bank7", exp_data[7], 32'hDEAD);
    start = 1'b1;
    run_dump(99, 0, 99, 32'd0, 1'b0);
    check_val("wr2_pairs", 32'(pairs_seen), 32'd16);
    check_val("wr2_checksum", checksum, 32'hDE92);

    // Reset during READ of idx 3
    tick();
    snapshot();
    start = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      if (busy && !out_valid && (rd_addr == 5'd3)) begin
        found = 1'b1;
        break;
      end
    end
    check_val("rst_reach", {31'd0, found}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mrst_rd_addr", {27'd0, rd_addr}, 32'd0);
    check_val("mrst_out_addr", {27'd0, out_addr}, 32'd0);
    check_val("mrst_out_data", out_data, 32'd0);
    check_val("mrst_checksum", checksum, 32'd0);
    check_idle_outputs("mrst");
    for (int c = 0; c < 4; c++) begin
      tick();
      check_idle_outputs("mrst_after");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
